// File: rtl/pe_column_feeder.sv
// Write-side driver for one PE column: turns load/run commands and a valid/ready word
// stream into registered columnControl strobes and kernel/neuron write data.
module pe_column_feeder #(
  parameter int         W         = 16,
  parameter int         A         = 7,
  parameter logic [5:0] CTRL_IDLE = 6'h00,
  parameter logic [5:0] CTRL_LOAD = 6'h01,
  parameter logic [5:0] CTRL_RUN  = 6'h02
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         cmdValid,
  output logic         cmdReady,
  input  logic [1:0]   cmdOp,
  input  logic [A:0]   cmdCount,
  input  logic         inValid,
  input  logic [W-1:0] inData,
  output logic         inReady,
  output logic [7:0]   columnControl,
  output logic [W-1:0] kernelIn,
  output logic [W-1:0] neuronIn,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [A:0] DEPTH   = {1'b1, {A{1'b0}}};
  localparam logic [A:0] ONE     = {{A{1'b0}}, 1'b1};
  localparam logic [1:0] OP_KERN = 2'b00;
  localparam logic [1:0] OP_NEUR = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;

  // Counts beyond the store depth would wrap the PE address; limit them to one full store.
  function automatic logic [A:0] clip_count(input logic [A:0] c);
    return (c > DEPTH) ? DEPTH : c;
  endfunction

  state_t       state_p0, state_p1;
  logic [1:0]   op_p0, op_p1;
  logic [A:0]   rem_p0, rem_p1;
  logic [7:0]   ctrl_p0, ctrl_p1;
  logic [W-1:0] kin_p0, kin_p1;
  logic [W-1:0] nin_p0, nin_p1;
  logic [A:0]   cnt;
  logic         cmd_acc;
  logic         word_acc;

  assign cmdReady = (state_p1 == S_IDLE) && !RST;
  assign inReady  = (state_p1 == S_LOAD) && (rem_p1 != '0);
  assign busy     = (state_p1 != S_IDLE);
  assign done     = (state_p1 == S_DONE);
  assign cmd_acc  = cmdValid && cmdReady;
  assign word_acc = inValid && inReady;

  // Stage p0: next-state and next-output decode
  always_comb begin
    state_p0 = state_p1;
    op_p0    = op_p1;
    rem_p0   = rem_p1;
    ctrl_p0  = {CTRL_IDLE, 2'b00};
    kin_p0   = kin_p1;
    nin_p0   = nin_p1;
    cnt      = clip_count(cmdCount);
    case (state_p1)
      S_IDLE: begin
        if (cmd_acc) begin
          op_p0  = cmdOp;
          rem_p0 = cnt;
          if (cnt == '0 || cmdOp == 2'b11) begin
            state_p0 = S_DONE;
          end else if (cmdOp == OP_RUN) begin
            state_p0 = S_RUN;
            ctrl_p0  = {CTRL_RUN, 2'b00};
          end else begin
            state_p0 = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (word_acc) begin
          rem_p0  = rem_p1 - ONE;
          ctrl_p0 = {CTRL_LOAD, op_p1 == OP_KERN, op_p1 == OP_NEUR};
          if (op_p1 == OP_KERN) kin_p0 = inData;
          else                  nin_p0 = inData;
          if (rem_p1 == ONE) state_p0 = S_DONE;
        end
      end
      S_RUN: begin
        // rem counts run cycles still to present, including the one on the outputs now.
        if (rem_p1 <= ONE) begin
          rem_p0   = '0;
          state_p0 = S_DONE;
        end else begin
          rem_p0  = rem_p1 - ONE;
          ctrl_p0 = {CTRL_RUN, 2'b00};
        end
      end
      default: state_p0 = S_IDLE;
    endcase
  end

  // Stage p1: registered state and column outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p1 <= S_IDLE;
      op_p1    <= '0;
      rem_p1   <= '0;
      ctrl_p1  <= {CTRL_IDLE, 2'b00};
      kin_p1   <= '0;
      nin_p1   <= '0;
    end else begin
      state_p1 <= state_p0;
      op_p1    <= op_p0;
      rem_p1   <= rem_p0;
      ctrl_p1  <= ctrl_p0;
      kin_p1   <= kin_p0;
      nin_p1   <= nin_p0;
    end
  end

  assign columnControl = ctrl_p1;
  assign kernelIn      = kin_p1;
  assign neuronIn      = nin_p1;

endmodule

// File: tb/tb_pe_column_feeder.sv
// Directed bench for pe_column_feeder: load, gapped load, run, clipping, reset abort, held cmdValid.
module tb_pe_column_feeder;
  localparam int W = 16;
  localparam int A = 7;

  logic         CLK = 1'b0;
  logic         RST;
  logic         cmdValid;
  logic         cmdReady;
  logic [1:0]   cmdOp;
  logic [A:0]   cmdCount;
  logic         inValid;
  logic [W-1:0] inData;
  logic         inReady;
  logic [7:0]   columnControl;
  logic [W-1:0] kernelIn;
  logic [W-1:0] neuronIn;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  pe_column_feeder #(.W(W), .A(A)) dut (
    .CLK(CLK), .RST(RST), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdCount(cmdCount), .inValid(inValid), .inData(inData), .inReady(inReady),
    .columnControl(columnControl), .kernelIn(kernelIn), .neuronIn(neuronIn),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [A:0] cnt);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdCount = cnt;
    tick();
    cmdValid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] expw;
    int  wr, n_sent, runs, errs;
    bit  acc, got_done;

    RST = 1'b1; cmdValid = 1'b0; cmdOp = '0; cmdCount = '0; inValid = 1'b0; inData = '0;
    tick(); tick();
    chk("rst_cmdReady", 32'(cmdReady), 0);
    chk("rst_ctrl", 32'(columnControl), 0);
    chk("rst_kernelIn", 32'(kernelIn), 0);
    chk("rst_busy_done", 32'({busy, done}), 0);
    RST = 1'b0; #1;
    chk("post_rst_cmdReady", 32'(cmdReady), 1);

    // 1: kernel load, 3 back-to-back words
    cmd(2'b00, 8'd3);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_inReady", 32'(inReady), 1);
    inValid = 1'b1; inData = 16'h0011; tick();
    chk("t1_w0", 32'({columnControl, kernelIn, done}), 32'({8'h06, 16'h0011, 1'b0}));
    inData = 16'h0022; tick();
    chk("t1_w1", 32'({columnControl, kernelIn, done}), 32'({8'h06, 16'h0022, 1'b0}));
    inData = 16'h0033; tick();
    chk("t1_w2", 32'({columnControl, kernelIn, done}), 32'({8'h06, 16'h0033, 1'b1}));
    chk("t1_neuronIn", 32'(neuronIn), 0);
    inValid = 1'b0; tick();
    chk("t1_idle", 32'({columnControl, done, cmdReady, busy}), 32'({8'h00, 1'b0, 1'b1, 1'b0}));

    // 2: neuron load, 2 words with a 4-cycle inValid gap
    cmd(2'b01, 8'd2);
    inValid = 1'b1; inData = 16'h00a1; tick();
    chk("t2_w0", 32'({columnControl, neuronIn}), 32'({8'h05, 16'h00a1}));
    inValid = 1'b0;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (columnControl !== 8'h00 || inReady !== 1'b1 || done !== 1'b0) errs++;
    end
    chk("t2_gap", 32'(errs), 0);
    inValid = 1'b1; inData = 16'h00b2; tick();
    chk("t2_w1", 32'({columnControl, neuronIn, done}), 32'({8'h05, 16'h00b2, 1'b1}));
    chk("t2_kernel_hold", 32'(kernelIn), 32'h0033);
    inValid = 1'b0; tick();
    chk("t2_idle", 32'({columnControl, done}), 0);

    // 3: run 5 cycles
    cmd(2'b10, 8'd5);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (columnControl !== 8'h08 || done !== 1'b0 || inReady !== 1'b0) errs++;
      tick();
    end
    chk("t3_run_cycles", 32'(errs), 0);
    chk("t3_done", 32'({columnControl, done, cmdReady}), 32'({8'h00, 1'b1, 1'b0}));
    tick();
    chk("t3_ready", 32'({cmdReady, done}), 32'({1'b1, 1'b0}));

    // 4: zero count, reserved op, clipped count
    cmd(2'b00, 8'd0);
    chk("t4_zero", 32'({columnControl, done, busy}), 32'({8'h00, 1'b1, 1'b1}));
    tick();
    chk("t4_zero_after", 32'(done), 0);
    cmd(2'b11, 8'd5);
    chk("t4_op11", 32'({columnControl, done}), 32'({8'h00, 1'b1}));
    tick();
    cmd(2'b00, 8'd200);
    inValid = 1'b1; n_sent = 0; inData = 16'h1000; wr = 0; errs = 0; got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      acc = inValid && inReady;
      tick();
      if (acc) begin n_sent++; inData = 16'h1000 + 16'(n_sent); end
      if (columnControl[1]) begin
        expw = 16'h1000 + 16'(wr);
        if (kernelIn !== expw) errs++;
        wr++;
      end
      if (done) got_done = 1'b1;
    end
    inValid = 1'b0;
    chk("t4_clip_done", 32'(got_done), 1);
    chk("t4_clip_writes", 32'(wr), 128);
    chk("t4_clip_order", 32'(errs), 0);
    tick();

    // 5: reset after 2 of 6 words
    cmd(2'b00, 8'd6);
    inValid = 1'b1; inData = 16'h0100; tick();
    inData = 16'h0101; tick();
    RST = 1'b1; inData = 16'h0102; tick();
    chk("t5_rst_out", 32'({columnControl, done, busy, cmdReady}), 0);
    chk("t5_rst_data", 32'({kernelIn, neuronIn}), 0);
    RST = 1'b0; inValid = 1'b0; #1;
    chk("t5_ready", 32'(cmdReady), 1);
    tick();
    chk("t5_quiet", 32'({columnControl, done, busy}), 0);
    cmd(2'b01, 8'd1);
    inValid = 1'b1; inData = 16'h0077; tick();
    chk("t5_reload", 32'({columnControl, neuronIn, done}), 32'({8'h05, 16'h0077, 1'b1}));
    inValid = 1'b0; tick();

    // 6: 128-word load, random inValid, cmdValid held high throughout
    cmd(2'b00, 8'd128);
    cmdValid = 1'b1; cmdOp = 2'b10; cmdCount = 8'd3;
    wr = 0; errs = 0; got_done = 1'b0;
    for (int c = 0; c < 2000 && !got_done; c++) begin
      inValid = 1'($urandom_range(0, 1));
      inData  = 16'($urandom);
      if (cmdReady !== 1'b0) errs++;
      if (inValid && inReady) q.push_back(inData);
      tick();
      if (columnControl[1]) begin
        if (q.size() == 0) errs++;
        else begin
          expw = q.pop_front();
          if (kernelIn !== expw) errs++;
        end
        wr++;
      end
      if (done) got_done = 1'b1;
    end
    inValid = 1'b0;
    chk("t6_done", 32'(got_done), 1);
    chk("t6_writes", 32'(wr), 128);
    chk("t6_order_ignore", 32'(errs), 0);
    chk("t6_leftover", 32'(q.size()), 0);
    tick();
    chk("t6_idle_ready", 32'({cmdReady, columnControl}), 32'({1'b1, 8'h00}));
    tick();
    chk("t6_run_start", 32'(columnControl), 32'h08);
    cmdValid = 1'b0;
    runs = 1; got_done = 1'b0;
    for (int c = 0; c < 10 && !got_done; c++) begin
      tick();
      if (columnControl == 8'h08) runs++;
      if (done) got_done = 1'b1;
    end
    chk("t6_run_done", 32'(got_done), 1);
    chk("t6_run_len", 32'(runs), 3);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
